// File: rtl/conv_phase_center_apply.sv
// conv_phase_center_apply
// Decodes the conv_phase_centers register word into per-channel phase-center
// table writes and subtracts the stored center from the channelised phase
// stream (modulo 2^PHASE_W). Fixed 2-cycle stream latency, no stalls.
// Optional clear sweep enabled by defining CONV_PHASE_CENTER_CLEAR_EN.
//
// state | meaning
// IDLE  | waiting for a stable toggle change (or clear edge)
// WRITE | one-cycle hold after a table write was issued
// CLEAR | sweeping zeros into entries 0..NCHAN-1 (feature build only)
module conv_phase_center_apply #(
  parameter int NCHAN   = 256,
  parameter int CHAN_W  = 8,
  parameter int PHASE_W = 16
) (
  input  logic               user_clk,
  input  logic               user_rst,
  input  logic [31:0]        reg_word,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic [CHAN_W-1:0]  phase_chan,
  input  logic               phase_valid,
  input  logic               phase_sync,
  output logic [PHASE_W-1:0] phase_out,
  output logic [CHAN_W-1:0]  out_chan,
  output logic               out_valid,
  output logic               out_sync,
  output logic [15:0]        load_count,
  output logic               busy
);

`ifdef CONV_PHASE_CENTER_CLEAR_EN
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE} state_t;
`endif

  state_t state, state_nxt;

  logic [31:0]        w1, w2;
  logic               tog_ref;
  logic               stable;
  logic               tog_chg;
  logic               accept;
  logic               wr_en;
  logic [CHAN_W-1:0]  wr_addr;
  logic [PHASE_W-1:0] wr_data;

  logic [PHASE_W-1:0] table_mem [NCHAN];
  logic [PHASE_W-1:0] center_rd;
  logic [PHASE_W-1:0] phase_d;
  logic [CHAN_W-1:0]  chan_d;
  logic               valid_d;
  logic               sync_d;

  // The whole word must match across both capture stages before it counts.
  assign stable  = (w1 == w2);
  assign tog_chg = stable && (w2[31] != tog_ref);

`ifdef CONV_PHASE_CENTER_CLEAR_EN
  logic              clr_ref;
  logic              clr_start;
  logic [CHAN_W-1:0] clr_cnt;

  assign clr_start = stable && w2[30] && !clr_ref;
  assign busy      = (state == CLEAR);

  // Clear-request edge reference and sweep down-counter (address = ~count).
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      clr_ref <= 1'b0;
      clr_cnt <= '0;
    end else begin
      if (stable) clr_ref <= w2[30];
      if (state == IDLE && clr_start) clr_cnt <= '1;
      else if (state == CLEAR)        clr_cnt <= clr_cnt - 1'b1;
    end
  end
`else
  assign busy = 1'b0;
`endif

  // Double-capture of the register word, toggle reference and write count.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      w1         <= '0;
      w2         <= '0;
      tog_ref    <= 1'b0;
      load_count <= '0;
      state      <= IDLE;
    end else begin
      w1    <= reg_word;
      w2    <= w1;
      state <= state_nxt;
      if (accept) begin
        tog_ref    <= w2[31];
        load_count <= load_count + 16'd1;
      end
    end
  end

  // Next-state and table-write port selection; clear wins over a toggle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = w2[CHAN_W+15:16];
    wr_data   = w2[PHASE_W-1:0];
    case (state)
      IDLE: begin
`ifdef CONV_PHASE_CENTER_CLEAR_EN
        if (clr_start) state_nxt = CLEAR;
        else
`endif
        if (tog_chg) begin
          state_nxt = WRITE;
          accept    = 1'b1;
          wr_en     = 1'b1;
        end
      end
      WRITE: state_nxt = IDLE;
`ifdef CONV_PHASE_CENTER_CLEAR_EN
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = ~clr_cnt;
        wr_data = '0;
        if (clr_cnt == '0) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Center table; contents intentionally survive reset.
  always_ff @(posedge user_clk) begin
    if (wr_en) table_mem[wr_addr] <= wr_data;
  end

  // Stream stage 1: table read with write-first bypass, input registration.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      center_rd <= '0;
      phase_d   <= '0;
      chan_d    <= '0;
      valid_d   <= 1'b0;
      sync_d    <= 1'b0;
    end else begin
      center_rd <= (wr_en && (wr_addr == phase_chan)) ? wr_data : table_mem[phase_chan];
      phase_d   <= phase_in;
      chan_d    <= phase_chan;
      valid_d   <= phase_valid;
      sync_d    <= phase_sync;
    end
  end

  // Stream stage 2: modular subtraction, qualifiers delayed alongside.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      phase_out <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      out_sync  <= 1'b0;
    end else begin
      phase_out <= phase_d - center_rd;
      out_chan  <= chan_d;
      out_valid <= valid_d;
      out_sync  <= sync_d;
    end
  end

endmodule

// File: tb/tb_conv_phase_center_apply.sv
// Testbench for conv_phase_center_apply: random stream and register traffic
// compared every cycle against a cycle-level reference model.
module tb_conv_phase_center_apply;
  localparam int NCHAN = 256;
  localparam int CHAN_W = 8;
  localparam int PHASE_W = 16;

  logic user_clk = 1'b0;
  logic user_rst;
  logic [31:0] reg_word;
  logic [PHASE_W-1:0] phase_in;
  logic [CHAN_W-1:0] phase_chan;
  logic phase_valid;
  logic phase_sync;
  logic [PHASE_W-1:0] phase_out;
  logic [CHAN_W-1:0] out_chan;
  logic out_valid;
  logic out_sync;
  logic [15:0] load_count;
  logic busy;

  conv_phase_center_apply #(.NCHAN(NCHAN), .CHAN_W(CHAN_W), .PHASE_W(PHASE_W)) dut (
    .user_clk(user_clk), .user_rst(user_rst), .reg_word(reg_word),
    .phase_in(phase_in), .phase_chan(phase_chan), .phase_valid(phase_valid),
    .phase_sync(phase_sync), .phase_out(phase_out), .out_chan(out_chan),
    .out_valid(out_valid), .out_sync(out_sync), .load_count(load_count), .busy(busy)
  );

  always #5 user_clk = ~user_clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] m_tbl [NCHAN];
  bit          m_known [NCHAN];
  logic [31:0] m_s1, m_s2;   // newest and previous register samples
  bit          m_tog, m_clr_ref;
  int          m_busy;       // clear entries still to go
  logic [15:0] m_cnt;
  // one stream sample in flight, plus the one now expected at the outputs
  logic [15:0] p_phase, e_phase;
  logic [7:0]  p_chan, e_chan;
  bit          p_valid, p_sync, p_known, e_valid, e_sync, e_known;

  bit drv_tog = 1'b0;
  bit drv_clr = 1'b0;
  int n_wr = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_tog = 0; m_clr_ref = 0; m_busy = 0; m_cnt = '0;
    p_phase = '0; p_chan = '0; p_valid = 0; p_sync = 0; p_known = 1;
  endtask

  // One active edge: register-side effects first, then the stream read
  // (which therefore sees a same-edge write).
  task automatic model_edge();
    bit stable, acted;
    logic [31:0] w;
    stable = (m_s1 == m_s2);
    w = m_s2;
    acted = 0;
`ifdef CONV_PHASE_CENTER_CLEAR_EN
    if (m_busy > 0) begin
      m_tbl[NCHAN - m_busy] = '0;
      m_known[NCHAN - m_busy] = 1;
      m_busy--;
      acted = 1;
    end else if (stable && w[30] && !m_clr_ref) begin
      m_busy = NCHAN;
      acted = 1;
    end
    if (stable) m_clr_ref = w[30];
`endif
    if (!acted && stable && (w[31] != m_tog)) begin
      m_tog = w[31];
      m_tbl[w[23:16]] = w[15:0];
      m_known[w[23:16]] = 1;
      m_cnt++;
    end
    m_s2 = m_s1;
    m_s1 = reg_word;
    e_phase = p_phase; e_chan = p_chan; e_valid = p_valid; e_sync = p_sync; e_known = p_known;
    p_phase = phase_in - m_tbl[phase_chan];
    p_chan = phase_chan;
    p_valid = phase_valid;
    p_sync = phase_sync;
    p_known = m_known[phase_chan];
  endtask

  task automatic cyc();
    @(posedge user_clk);
    #1;
    if (user_rst) begin
      model_reset();
      e_phase = '0; e_chan = '0; e_valid = 0; e_sync = 0; e_known = 1;
    end else begin
      model_edge();
    end
    check("out_valid", out_valid, e_valid);
    check("out_sync", out_sync, e_sync);
    check("out_chan", out_chan, e_chan);
    if (e_known) check("phase_out", phase_out, e_phase);
    check("load_count", load_count, m_cnt);
    check("busy", busy, m_busy > 0);
  endtask

  task automatic wr(int ch, logic [15:0] c);
    drv_tog = ~drv_tog;
    reg_word = {drv_tog, drv_clr, 6'd0, ch[7:0], c};
    repeat (4) cyc();
    n_wr++;
  endtask

  task automatic stream(string tag, int ch, logic [15:0] ph, logic [15:0] exp);
    phase_chan = ch[7:0]; phase_in = ph; phase_valid = 1; phase_sync = 0;
    cyc();
    phase_valid = 0;
    cyc();
    check(tag, phase_out, exp);
    check({tag, "_chan"}, out_chan, ch);
    check({tag, "_valid"}, out_valid, 1);
  endtask

  initial begin
    for (int i = 0; i < NCHAN; i++) begin m_tbl[i] = '0; m_known[i] = 0; end
    model_reset();
    user_rst = 1; reg_word = '0; phase_in = '0; phase_chan = '0; phase_valid = 0; phase_sync = 0;
    #2;
    check("rst_phase_out", phase_out, 0);
    check("rst_load_count", load_count, 0);
    check("rst_out_valid", out_valid, 0);
    repeat (2) cyc();
    user_rst = 0;
    cyc();

    // first write: count visible on the third edge
    drv_tog = 1;
    reg_word = {1'b1, 1'b0, 6'd0, 8'd5, 16'h0100};
    cyc(); cyc();
    check("cnt_before", load_count, 0);
    cyc();
    check("cnt_after", load_count, 1);
    n_wr = 1;
    cyc();
    stream("basic", 5, 16'h0180, 16'h0080);

    // modular wrap
    wr(3, 16'hFFFF);
    stream("wrap_pos", 3, 16'h7FFF, 16'h8000);
    wr(3, 16'h0001);
    stream("wrap_neg", 3, 16'h8000, 16'h7FFF);

    // unchanged toggle bit: no write
    reg_word = {drv_tog, 1'b0, 6'd0, 8'd3, 16'h5555};
    repeat (5) cyc();
    check("repeat_cnt", load_count, n_wr);
    stream("repeat_val", 3, 16'h8000, 16'h7FFF);

    // two words on consecutive cycles: only the last one lands
    wr(8, 16'h0AAA);
    drv_tog = ~drv_tog;
    reg_word = {drv_tog, 1'b0, 6'd0, 8'd8, 16'h1111};
    cyc();
    reg_word = {drv_tog, 1'b0, 6'd0, 8'd9, 16'h2222};
    repeat (4) cyc();
    n_wr++;
    check("consec_cnt", load_count, n_wr);
    stream("consec_new", 9, 16'h3333, 16'h1111);
    stream("consec_old", 8, 16'h0AAA, 16'h0000);

    // same-cycle write and read of one entry
    wr(7, 16'h0500);
    drv_tog = ~drv_tog;
    reg_word = {drv_tog, 1'b0, 6'd0, 8'd7, 16'h0010};
    n_wr++;
    cyc(); cyc();
    phase_chan = 8'd7; phase_in = 16'h0020; phase_valid = 1;
    cyc();
    phase_valid = 0;
    cyc();
    check("collide", phase_out, 16'h0010);

    // load channels 0..15, then random traffic
    for (int i = 0; i < 16; i++) wr(i, 16'($urandom));
    for (int n = 0; n < 3000; n++) begin
      phase_in = 16'($urandom);
      phase_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        phase_chan = '0; phase_sync = 1;
      end else begin
        phase_chan = 8'($urandom_range(0, 15)); phase_sync = 0;
      end
      if ($urandom_range(0, 5) == 0) begin
        logic [31:0] r;
        r = $urandom;
        r[23:16] = 8'($urandom_range(0, 15));
        r[30] = ($urandom_range(0, 63) == 0);
        reg_word = r;
      end
      cyc();
    end
    phase_valid = 0; phase_sync = 0;
    drv_tog = reg_word[31];
    drv_clr = 0;
    reg_word[30] = 1'b0;
    repeat (300) cyc();
    n_wr = int'(m_cnt);

`ifdef CONV_PHASE_CENTER_CLEAR_EN
    begin
      int nb;
      bit seen, fell;
      wr(10, 16'h1234);
      drv_clr = 1;
      reg_word[30] = 1'b1;
      nb = 0; seen = 0; fell = 0;
      for (int n = 0; n < 600 && !fell; n++) begin
        cyc();
        if (busy) begin
          nb++; seen = 1;
          if (nb == 100) begin
            drv_tog = ~drv_tog;
            reg_word = {drv_tog, drv_clr, 6'd0, 8'd11, 16'h0777};
            n_wr++;
          end
        end else if (seen) fell = 1;
      end
      check("busy_len", nb, NCHAN);
      repeat (3) cyc();
      check("clr_cnt", load_count, n_wr);
      stream("clr_zero", 10, 16'h1234, 16'h1234);
      stream("clr_late_tog", 11, 16'h1000, 16'h0889);
      drv_clr = 0;
      reg_word[30] = 1'b0;
      repeat (4) cyc();
      reg_word[30] = 1'b1;
      repeat (50) cyc();
      check("busy_mid", busy, 1);
      user_rst = 1;
      #1;
      check("busy_rst", busy, 0);
      check("cnt_rst", load_count, 0);
      reg_word = '0; drv_tog = 0;
      repeat (2) cyc();
      user_rst = 0;
      repeat (4) cyc();
      stream("rst_partial", 15, 16'h0042, 16'h0042);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
